reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//   In-order completion buffer for the issue/bypass stage. Allocates one entry per issued instruction,
//   collects out-of-order writebacks, and retires results in program order to the register file.
//   Exposes two combinational source-lookup ports. These drive the ROB producer slots of the hazard/bypass
//   check: valid = in-flight writer found, we = result ready, data = result.
// PARAMETERS
//   ENTRIES       8    number of ROB entries (power of two)
//   TAG_BITS      3    log2(ENTRIES); width of entry tags
//   ARCH_BITS     32   data width (proc-wide constant)
//   REG_IDX_BITS  5    architectural register index width (proc-wide constant)
// PORTS
//   clk          in   1             clock; all state updates on rising edge
//   rst          in   1             synchronous reset, active-high
//   alloc_valid  in   1             request to allocate an entry at tail
//   alloc_dst    in   REG_IDX_BITS  destination register of the allocating instruction
//   alloc_rwe    in   1             instruction writes a register
//   alloc_ready  out  1             buffer not full
//   alloc_tag    out  TAG_BITS      tag assigned to the current alloc (= tail pointer)
//   wb_valid     in   1             execution result return
//   wb_tag       in   TAG_BITS      entry being completed
//   wb_data      in   ARCH_BITS     result value
//   src1_idx     in   REG_IDX_BITS  lookup register, port 1 (src2_* identical for port 2)
//   src1_valid   out  1             an allocated entry with rwe=1 targets src1_idx
//   src1_dst     out  REG_IDX_BITS  echoes src1_idx
//   src1_we      out  1             the matched entry is complete (bypassable)
//   src1_data    out  ARCH_BITS     matched entry's data; 32'hFFFFFFFF when no match
//   commit_valid out  1             head entry retiring this cycle
//   commit_dst   out  REG_IDX_BITS  retiring destination register
//   commit_we    out  1             retiring entry writes the register file (head rwe)
//   commit_data  out  ARCH_BITS     retiring value
//   flush        in   1             discard all in-flight entries
//   count        out  TAG_BITS+1    occupied entries
// BEHAVIOUR
//   - Reset/flush (same-cycle priority: rst > flush > commit/wb/alloc)
//     - head=tail=count=0; all entry valid/done bits clear.
//     - Outputs next cycle: alloc_ready=1, commit_valid=0, src*_valid=0.
//     - alloc/wb presented in a flush cycle are dropped.
//   - Alloc
//     - Fires when alloc_valid && alloc_ready.
//     - Entry[tail] <= {valid=1, done=0, dst, rwe}; tail wraps ENTRIES-1 -> 0.
//     - alloc_ready = (count != ENTRIES), computed from registered count only.
//     - A commit in the same cycle does not free a slot for that cycle's alloc.
//   - Writeback: if wb_valid && entry[wb_tag].valid, then done <= 1 and data <= wb_data. Writebacks to invalid tags are ignored.
//   - Commit (combinational)
//     - commit_valid = entry[head].valid && entry[head].done.
//     - When set, head wraps to head+1 and the entry is cleared at the edge. Max one commit per cycle.
//   - Count update: count += alloc_fire - commit_fire; simultaneous alloc+commit leaves count unchanged.
//   - Lookup (combinational)
//     - Search valid entries with rwe=1 && dst==srcN_idx, youngest first (tail-1 back to head).
//     - The first hit is reported; older hits are shadowed.
//     - srcN_we = hit.done. No hit -> valid=0, we=0.
//   - Latency
//     - Alloc to lookup visibility: 1 cycle.
//     - Writeback to we=1: 1 cycle.
//     - Writeback to commit_valid: 1 cycle if the entry is at head.
// CONFIGURATION
//   ROB_WB_FORWARD_EN defined
//     - Lookup treats the entry at wb_tag as done with data=wb_data in the writeback cycle (0-cycle bypass).
//     - Commit timing is unchanged.
//   ROB_WB_FORWARD_EN undefined: completion is visible to lookup only from the next cycle.
// STRUCTURE
//   - ROB_ENTRIES, ROB_TAG_BITS and entry field localparams live in the proc-wide constants package,
//     next to ARCH_BITS and REG_IDX_BITS.
//   - Sub-module rob_youngest_match: age-ordered priority match over the entry array.
//     One instance per lookup port; it takes head, tail, valid/rwe/dst/done/data vectors and srcN_idx.
// TESTING
//   1. rst high 2 cycles -> alloc_ready=1, count=0, commit_valid=0, src1_valid=src2_valid=0.
//   2. 8 allocs dst r1..r8 -> alloc_tag 0..7, count=8, alloc_ready=0; 9th alloc ignored, count stays 8.
//   3. Alloc r3 (tag0), alloc r3 (tag1), wb tag0=0x11 -> src1_idx=r3 gives valid=1, we=0 (tag1 shadows).
//      Then wb tag1=0x22 -> we=1, data=0x22.
//   4. Alloc tags 0,1,2; wb order 2,1,0 -> commit_valid on 3 consecutive cycles, tags 0,1,2 in order, data matches.
//   5. Stream 12 alloc/wb/commit -> tags wrap 7->0, count never exceeds 8, commits stay in order.
//   6. 5 in flight, flush with alloc_valid=1 -> count=0, no commit; next alloc gets tag 0.
//      With ROB_WB_FORWARD_EN: wb tag0=0x55 -> src1_we=1, data=0x55 same cycle; without, one cycle later.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Proc-wide constants shared by the reorder buffer and its lookup matcher:
// data/register widths, ROB geometry and the per-entry bookkeeping record.
package reorder_buffer_pkg;

  localparam int ARCH_BITS    = 32;
  localparam int REG_IDX_BITS = 5;
  localparam int ROB_ENTRIES  = 8;
  localparam int ROB_TAG_BITS = 3;

  // Data reported by a lookup port when no in-flight writer matches.
  localparam logic [ARCH_BITS-1:0] ROB_NO_MATCH_DATA = '1;

  // Occupancy value at which the buffer refuses further allocations.
  localparam logic [ROB_TAG_BITS:0] ROB_COUNT_FULL = (ROB_TAG_BITS+1)'(ROB_ENTRIES);

  // Control fields of one entry; the result data lives in a separate array.
  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic                    rwe;
    logic [REG_IDX_BITS-1:0] dst;
  } rob_entry_t;

  // Circular pointer advance; wraps naturally at the power-of-two size.
  function automatic logic [ROB_TAG_BITS-1:0] rob_tag_inc(input logic [ROB_TAG_BITS-1:0] t);
    return t + ROB_TAG_BITS'(1);
  endfunction

endpackage

// File: rtl/rob_youngest_match.sv
// Age-ordered priority match over the ROB entry array. Scans from the
// youngest entry (tail-1) back to the oldest (head) and reports the first
// valid, register-writing entry whose destination equals src_idx.
module rob_youngest_match
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_TAG_BITS-1:0]                    head,
  input  logic [ROB_TAG_BITS-1:0]                    tail,
  input  logic [ROB_ENTRIES-1:0]                     valid,
  input  logic [ROB_ENTRIES-1:0]                     rwe,
  input  logic [ROB_ENTRIES-1:0]                     done,
  input  logic [ROB_ENTRIES-1:0][REG_IDX_BITS-1:0]   dst,
  input  logic [ROB_ENTRIES-1:0][ARCH_BITS-1:0]      data,
  input  logic [REG_IDX_BITS-1:0]                    src_idx,
  output logic                                       hit_valid,
  output logic [REG_IDX_BITS-1:0]                    hit_dst,
  output logic                                       hit_we,
  output logic [ARCH_BITS-1:0]                       hit_data
);

  logic [ROB_TAG_BITS-1:0] idx;
  logic                    stop;

  assign hit_dst = src_idx;

  // Youngest-first search; reaching head ends the scan (when full, head is
  // visited last, since tail == head and tail-ENTRIES wraps onto it).
  always_comb begin
    hit_valid = 1'b0;
    hit_we    = 1'b0;
    hit_data  = ROB_NO_MATCH_DATA;
    stop      = 1'b0;
    idx       = '0;
    for (int k = 1; k <= ROB_ENTRIES; k++) begin
      idx = tail - ROB_TAG_BITS'(k);
      if (!stop && valid[idx] && rwe[idx] && (dst[idx] == src_idx)) begin
        hit_valid = 1'b1;
        hit_we    = done[idx];
        hit_data  = data[idx];
        stop      = 1'b1;
      end
      if (idx == head) stop = 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order completion buffer: allocates at tail, collects out-of-order
// writebacks, retires from head in program order, and offers two
// youngest-writer lookup ports for the hazard/bypass check.
// Optional macro ROB_WB_FORWARD_EN: lookups see a writeback in the same
// cycle it arrives (commit timing unaffected).
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  input  logic [REG_IDX_BITS-1:0] alloc_dst,
  input  logic                    alloc_rwe,
  output logic                    alloc_ready,
  output logic [ROB_TAG_BITS-1:0] alloc_tag,
  input  logic                    wb_valid,
  input  logic [ROB_TAG_BITS-1:0] wb_tag,
  input  logic [ARCH_BITS-1:0]    wb_data,
  input  logic [REG_IDX_BITS-1:0] src1_idx,
  output logic                    src1_valid,
  output logic [REG_IDX_BITS-1:0] src1_dst,
  output logic                    src1_we,
  output logic [ARCH_BITS-1:0]    src1_data,
  input  logic [REG_IDX_BITS-1:0] src2_idx,
  output logic                    src2_valid,
  output logic [REG_IDX_BITS-1:0] src2_dst,
  output logic                    src2_we,
  output logic [ARCH_BITS-1:0]    src2_data,
  output logic                    commit_valid,
  output logic [REG_IDX_BITS-1:0] commit_dst,
  output logic                    commit_we,
  output logic [ARCH_BITS-1:0]    commit_data,
  input  logic                    flush,
  output logic [ROB_TAG_BITS:0]   count
);

  rob_entry_t [ROB_ENTRIES-1:0] ent_q, ent_d;
  logic [ARCH_BITS-1:0]         data_q [ROB_ENTRIES];
  logic [ROB_TAG_BITS-1:0]      head_q, head_d, tail_q, tail_d;
  logic [ROB_TAG_BITS:0]        count_q, count_d;

  logic alloc_fire, wb_fire;

  // Full test uses registered occupancy only, so a same-cycle commit never
  // opens a slot for the allocation presented alongside it.
  assign alloc_ready  = (count_q != ROB_COUNT_FULL);
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign wb_fire      = wb_valid && ent_q[wb_tag].valid;
  assign alloc_tag    = tail_q;
  assign count        = count_q;

  assign commit_valid = ent_q[head_q].valid && ent_q[head_q].done;
  assign commit_dst   = ent_q[head_q].dst;
  assign commit_we    = ent_q[head_q].rwe;
  assign commit_data  = data_q[head_q];

  // Next-state for entry control, pointers and occupancy; flush discards all.
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      ent_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wb_fire) ent_d[wb_tag].done = 1'b1;
      if (alloc_fire) begin
        ent_d[tail_q] = '{valid: 1'b1, done: 1'b0, rwe: alloc_rwe, dst: alloc_dst};
        tail_d        = rob_tag_inc(tail_q);
      end
      if (commit_valid) begin
        ent_d[head_q] = '0;
        head_d        = rob_tag_inc(head_q);
      end
      count_d = count_q + {{ROB_TAG_BITS{1'b0}}, alloc_fire}
                        - {{ROB_TAG_BITS{1'b0}}, commit_valid};
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Result storage; contents are only meaningful while the entry is done.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wb_fire) data_q[wb_tag] <= wb_data;
  end

  // Lookup view of the entry array, optionally with same-cycle writeback.
  logic [ROB_ENTRIES-1:0]                   lk_valid, lk_rwe, lk_done;
  logic [ROB_ENTRIES-1:0][REG_IDX_BITS-1:0] lk_dst;
  logic [ROB_ENTRIES-1:0][ARCH_BITS-1:0]    lk_data;

  for (genvar gi = 0; gi < ROB_ENTRIES; gi++) begin : g_lk
    assign lk_valid[gi] = ent_q[gi].valid;
    assign lk_rwe[gi]   = ent_q[gi].rwe;
    assign lk_dst[gi]   = ent_q[gi].dst;
`ifdef ROB_WB_FORWARD_EN
    logic fwd_hit;
    assign fwd_hit     = wb_valid && (wb_tag == ROB_TAG_BITS'(gi));
    assign lk_done[gi] = ent_q[gi].done || fwd_hit;
    assign lk_data[gi] = fwd_hit ? wb_data : data_q[gi];
`else
    assign lk_done[gi] = ent_q[gi].done;
    assign lk_data[gi] = data_q[gi];
`endif
  end

  rob_youngest_match u_match1 (
    .head(head_q), .tail(tail_q), .valid(lk_valid), .rwe(lk_rwe),
    .done(lk_done), .dst(lk_dst), .data(lk_data), .src_idx(src1_idx),
    .hit_valid(src1_valid), .hit_dst(src1_dst), .hit_we(src1_we), .hit_data(src1_data)
  );

  rob_youngest_match u_match2 (
    .head(head_q), .tail(tail_q), .valid(lk_valid), .rwe(lk_rwe),
    .done(lk_done), .dst(lk_dst), .data(lk_data), .src_idx(src2_idx),
    .hit_valid(src2_valid), .hit_dst(src2_dst), .hit_we(src2_we), .hit_data(src2_data)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst, flush;
  logic                    alloc_valid, alloc_rwe, alloc_ready;
  logic [REG_IDX_BITS-1:0] alloc_dst;
  logic [ROB_TAG_BITS-1:0] alloc_tag;
  logic                    wb_valid;
  logic [ROB_TAG_BITS-1:0] wb_tag;
  logic [ARCH_BITS-1:0]    wb_data;
  logic [REG_IDX_BITS-1:0] src1_idx, src2_idx, src1_dst, src2_dst;
  logic                    src1_valid, src1_we, src2_valid, src2_we;
  logic [ARCH_BITS-1:0]    src1_data, src2_data;
  logic                    commit_valid, commit_we;
  logic [REG_IDX_BITS-1:0] commit_dst;
  logic [ARCH_BITS-1:0]    commit_data;
  logic [ROB_TAG_BITS:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dst(alloc_dst), .alloc_rwe(alloc_rwe),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .src1_idx(src1_idx), .src1_valid(src1_valid), .src1_dst(src1_dst),
    .src1_we(src1_we), .src1_data(src1_data),
    .src2_idx(src2_idx), .src2_valid(src2_valid), .src2_dst(src2_dst),
    .src2_we(src2_we), .src2_data(src2_data),
    .commit_valid(commit_valid), .commit_dst(commit_dst),
    .commit_we(commit_we), .commit_data(commit_data),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, obs);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_dst = '0; alloc_rwe = 1'b1;
    wb_valid = 1'b0; wb_tag = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_alloc(input logic [REG_IDX_BITS-1:0] d);
    alloc_valid = 1'b1; alloc_dst = d; alloc_rwe = 1'b1;
    tick();
    alloc_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    src1_idx = '0; src2_idx = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    // 1. reset state
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_src1_valid", src1_valid, 0);
    chk("rst_src2_valid", src2_valid, 0);

    // 2. fill to capacity, then an extra alloc is refused
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_dst = REG_IDX_BITS'(i + 1); alloc_rwe = 1'b1;
      #1;
      chk($sformatf("fill_tag%0d", i), alloc_tag, i);
      tick();
    end
    alloc_valid = 1'b0;
    chk("full_count", count, 8);
    chk("full_alloc_ready", alloc_ready, 0);
    alloc_valid = 1'b1; alloc_dst = 5'd9;
    tick();
    alloc_valid = 1'b0;
    chk("full_9th_ignored", count, 8);
    src1_idx = 5'd5; src2_idx = 5'd9;
    #1;
    chk("full_src1_valid", src1_valid, 1);
    chk("full_src1_we", src1_we, 0);
    chk("full_src1_dst", src1_dst, 5);
    chk("full_src2_valid", src2_valid, 0);
    chk("full_src2_data", src2_data, 32'hFFFF_FFFF);
    do_flush();
    chk("flush_count", count, 0);
    chk("flush_alloc_ready", alloc_ready, 1);

    // 3. youngest writer shadows older completed one
    do_alloc(5'd3);
    do_alloc(5'd3);
    wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 32'h11;
    src1_idx = 5'd3;
    tick();
    wb_valid = 1'b0;
    chk("shadow_valid", src1_valid, 1);
    chk("shadow_we", src1_we, 0);
    chk("shadow_commit_valid", commit_valid, 1);
    chk("shadow_commit_data", commit_data, 32'h11);
    wb_valid = 1'b1; wb_tag = 3'd1; wb_data = 32'h22;
    #1;
`ifdef ROB_WB_FORWARD_EN
    chk("wb_cycle_we", src1_we, 1);
    chk("wb_cycle_data", src1_data, 32'h22);
`else
    chk("wb_cycle_we", src1_we, 0);
`endif
    tick();
    wb_valid = 1'b0;
    chk("wb1_we", src1_we, 1);
    chk("wb1_data", src1_data, 32'h22);
    chk("wb1_commit_data", commit_data, 32'h22);
    chk("wb1_commit_dst", commit_dst, 3);
    tick();
    chk("t3_drained", count, 0);
    chk("t3_commit_idle", commit_valid, 0);

    // 4. out-of-order writeback, in-order commit
    do_flush();
    do_alloc(5'd10); do_alloc(5'd11); do_alloc(5'd12);
    for (int k = 2; k >= 0; k--) begin
      wb_valid = 1'b1; wb_tag = ROB_TAG_BITS'(k); wb_data = 32'hA0 + k;
      tick();
      if (k != 0) chk($sformatf("ooo_hold%0d", k), commit_valid, 0);
    end
    wb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ooo_cv%0d", k), commit_valid, 1);
      chk($sformatf("ooo_dst%0d", k), commit_dst, 10 + k);
      chk($sformatf("ooo_data%0d", k), commit_data, 32'hA0 + k);
      chk($sformatf("ooo_we%0d", k), commit_we, 1);
      tick();
    end
    chk("ooo_commit_idle", commit_valid, 0);
    chk("ooo_count", count, 0);

    // 5. streaming with wrap (head=tail=3 here)
    for (int i = 0; i < 14; i++) begin
      int exp_cnt;
      alloc_valid = (i < 12); alloc_dst = REG_IDX_BITS'(i + 1); alloc_rwe = 1'b1;
      wb_valid = (i >= 1 && i <= 12);
      wb_tag = ROB_TAG_BITS'((3 + i - 1) % 8);
      wb_data = 32'h100 + i - 1;
      #1;
      exp_cnt = ((i < 12) ? i : 12) - ((i > 2) ? i - 2 : 0);
      chk($sformatf("strm_count%0d", i), count, exp_cnt);
      if (i < 12) chk($sformatf("strm_tag%0d", i), alloc_tag, (3 + i) % 8);
      chk($sformatf("strm_cv%0d", i), commit_valid, (i >= 2));
      if (i >= 2) chk($sformatf("strm_cdata%0d", i), commit_data, 32'h100 + i - 2);
      tick();
    end
    idle_inputs();
    chk("strm_drained", count, 0);

    // 6. flush with in-flight entries and a concurrent alloc
    do_flush();
    for (int i = 0; i < 5; i++) do_alloc(REG_IDX_BITS'(20 + i));
    chk("f6_count5", count, 5);
    flush = 1'b1; alloc_valid = 1'b1; alloc_dst = 5'd25;
    tick();
    idle_inputs();
    src1_idx = 5'd20;
    #1;
    chk("f6_count0", count, 0);
    chk("f6_commit", commit_valid, 0);
    chk("f6_src1_valid", src1_valid, 0);
    alloc_valid = 1'b1; alloc_dst = 5'd7;
    #1;
    chk("f6_tag0", alloc_tag, 0);
    tick();
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 32'h55; src1_idx = 5'd7;
    #1;
    chk("f6_wbc_valid", src1_valid, 1);
`ifdef ROB_WB_FORWARD_EN
    chk("f6_wbc_we", src1_we, 1);
    chk("f6_wbc_data", src1_data, 32'h55);
`else
    chk("f6_wbc_we", src1_we, 0);
`endif
    tick();
    wb_valid = 1'b0;
    chk("f6_we", src1_we, 1);
    chk("f6_data", src1_data, 32'h55);
    chk("f6_commit_data", commit_data, 32'h55);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
